// File: rtl/jtframe_bank_resp.sv
// BRAM-backed responder for the jtframe bank request/ack/dst/rdy handshake.
// Fixed-latency reads and byte-masked writes, plus a preload port used while downloading.
`timescale 1ns/1ps

module jtframe_bank_resp #(
    parameter int unsigned AW      = 22,
    parameter int unsigned MEMAW   = 10,
    parameter int unsigned LATENCY = 3
) (
    input  logic             rst,
    input  logic             clk,
    input  logic [AW-1:0]    ba_addr,
    input  logic             ba_rd,
    input  logic             ba_wr,
    input  logic [15:0]      ba_din,
    input  logic [1:0]       ba_din_m,
    output logic             ba_ack,
    output logic             ba_dst,
    output logic             ba_rdy,
    output logic [15:0]      data_read,
    input  logic             downloading,
    input  logic             prog_we,
    input  logic [MEMAW-1:0] prog_addr,
    input  logic [15:0]      prog_data
);

    localparam int unsigned DEPTH    = 1 << MEMAW;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DATA, DONE} state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [MEMAW-1:0] addr_q;
    logic [15:0]      din_q;
    logic [1:0]       mask_q;
    logic             wr_q;
    logic             ack_nx, dst_nx, rdy_nx;
    logic             capture, commit, rd_fire;
    logic [15:0]      mem [DEPTH];

    // Upper address bits are intentionally dropped; addresses wrap in the BRAM.
    logic unused_addr;
    assign unused_addr = ^ba_addr;

    // State, counter, captured request and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            din_q     <= 16'd0;
            mask_q    <= 2'b00;
            wr_q      <= 1'b0;
            ba_ack    <= 1'b0;
            ba_dst    <= 1'b0;
            ba_rdy    <= 1'b0;
            data_read <= 16'd0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ba_ack <= ack_nx;
            ba_dst <= dst_nx;
            ba_rdy <= rdy_nx;
            if (capture) begin
                addr_q <= ba_addr[MEMAW-1:0];
                din_q  <= ba_din;
                mask_q <= ba_din_m;
                wr_q   <= ba_wr;
            end
            if (rd_fire) data_read <= mem[addr_q];
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ack_nx   = 1'b0;
        dst_nx   = 1'b0;
        rdy_nx   = 1'b0;
        capture  = 1'b0;
        commit   = 1'b0;
        rd_fire  = 1'b0;
        case (state)
            IDLE: begin
                if ((ba_rd || ba_wr) && !downloading) begin
                    capture  = 1'b1;
                    ack_nx   = 1'b1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    if (wr_q) begin
                        commit   = 1'b1;
                        rdy_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        rd_fire  = 1'b1;
                        dst_nx   = 1'b1;
                        state_nx = DATA;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DATA: begin
                rdy_nx   = 1'b1;
                state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // BRAM write port; the preload write is last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (!mask_q[0]) mem[addr_q][7:0]  <= din_q[7:0];
            if (!mask_q[1]) mem[addr_q][15:8] <= din_q[15:8];
        end
        if (downloading && prog_we) mem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_jtframe_bank_resp.sv
// Directed bench for jtframe_bank_resp: table of single transactions plus
// hand sequences for reset abort, held requests, downloading and preload collisions.
`timescale 1ns/1ps

module tb_jtframe_bank_resp;

    logic        rst, clk;
    logic [21:0] ba_addr;
    logic        ba_rd, ba_wr;
    logic [15:0] ba_din;
    logic [1:0]  ba_din_m;
    logic        ba_ack, ba_dst, ba_rdy;
    logic [15:0] data_read;
    logic        downloading, prog_we;
    logic [9:0]  prog_addr;
    logic [15:0] prog_data;

    int checks   = 0;
    int failures = 0;

    jtframe_bank_resp #(.AW(22), .MEMAW(10), .LATENCY(3)) dut (
        .rst(rst), .clk(clk), .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr),
        .ba_din(ba_din), .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_dst(ba_dst),
        .ba_rdy(ba_rdy), .data_read(data_read), .downloading(downloading),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  m;
        logic [15:0] exp_data;
        int          exp_dst;
        int          exp_rdy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        downloading = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        downloading = 1'b0; prog_we = 1'b0;
    endtask

    // Runs one request for 14 cycles, recording the cycle offsets of handshake pulses.
    task automatic run_txn(input logic rd, input logic wr, input logic [21:0] a,
                           input logic [15:0] d, input logic [1:0] m, input int hold,
                           input int prog_at, input logic [9:0] pa, input logic [15:0] pd,
                           input int rst_at,
                           output int ack1, output int ack2, output int dst1, output int rdy1,
                           output int n_ack, output int n_dst, output int n_rdy,
                           output logic [15:0] rdat);
        ack1 = -1; ack2 = -1; dst1 = -1; rdy1 = -1;
        n_ack = 0; n_dst = 0; n_rdy = 0;
        @(negedge clk);
        ba_rd = rd; ba_wr = wr; ba_addr = a; ba_din = d; ba_din_m = m;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("exclusive@%0d", k), int'(ba_ack) + int'(ba_dst) + int'(ba_rdy) <= 1, 1);
            if (ba_ack) begin
                if (n_ack == 0) ack1 = k; else ack2 = k;
                n_ack++;
                if (hold == 0) begin ba_rd = 1'b0; ba_wr = 1'b0; end
            end
            if (ba_dst) begin if (n_dst == 0) dst1 = k; n_dst++; end
            if (ba_rdy) begin if (n_rdy == 0) rdy1 = k; n_rdy++; end
            if (hold != 0 && k == hold) begin ba_rd = 1'b0; ba_wr = 1'b0; end
            if (prog_at != 0) begin
                downloading = (k == prog_at); prog_we = (k == prog_at);
                prog_addr = pa; prog_data = pd;
            end
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_outputs", {ba_ack, ba_dst, ba_rdy, data_read}, 0);
            end
            if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
        end
        rdat = data_read;
    endtask

    int ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy;
    logic [15:0] rdat;

    initial begin
        rst = 1'b1; ba_addr = '0; ba_rd = 1'b0; ba_wr = 1'b0; ba_din = '0; ba_din_m = '0;
        downloading = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        vecs[0] = '{1'b1, 1'b0, 22'h000005, 16'h0000, 2'b00, 16'hBEEF, 4, 5};
        vecs[1] = '{1'b0, 1'b1, 22'h000010, 16'h1234, 2'b10, 16'hBEEF, -1, 4};
        vecs[2] = '{1'b1, 1'b0, 22'h000010, 16'h0000, 2'b00, 16'hFF34, 4, 5};
        vecs[3] = '{1'b1, 1'b1, 22'h0003FF, 16'hA5A5, 2'b00, 16'hFF34, -1, 4};
        vecs[4] = '{1'b1, 1'b0, 22'h0007FF, 16'h0000, 2'b00, 16'hA5A5, 4, 5};
        vecs[5] = '{1'b0, 1'b1, 22'h000100, 16'h0000, 2'b11, 16'hA5A5, -1, 4};
        vecs[6] = '{1'b1, 1'b0, 22'h000100, 16'h0000, 2'b00, 16'hCAFE, 4, 5};
        vecs[7] = '{1'b0, 1'b1, 22'h000100, 16'h5678, 2'b01, 16'hCAFE, -1, 4};
        vecs[8] = '{1'b1, 1'b0, 22'h000100, 16'h0000, 2'b00, 16'h56FE, 4, 5};
        vecs[9] = '{1'b1, 1'b0, 22'h3FFC05, 16'h0000, 2'b00, 16'hBEEF, 4, 5};

        #12;
        check("reset_outputs", {ba_ack, ba_dst, ba_rdy, data_read}, 0);
        @(negedge clk);
        rst = 1'b0;

        preload(10'h005, 16'hBEEF);
        preload(10'h010, 16'hFFFF);
        preload(10'h020, 16'h1111);
        preload(10'h3FF, 16'h0000);
        preload(10'h100, 16'hCAFE);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].m, 0,
                    0, 10'h0, 16'h0, 0, ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
            check($sformatf("v%0d_ack", i), ack1, 1);
            check($sformatf("v%0d_dst", i), dst1, vecs[i].exp_dst);
            check($sformatf("v%0d_rdy", i), rdy1, vecs[i].exp_rdy);
            check($sformatf("v%0d_pulses", i), n_ack * 100 + n_dst * 10 + n_rdy,
                  vecs[i].exp_dst < 0 ? 101 : 111);
            check($sformatf("v%0d_data", i), int'(rdat), int'(vecs[i].exp_data));
        end

        // Reset during WAIT of a write aborts it and leaves the word alone.
        run_txn(1'b0, 1'b1, 22'h000020, 16'h9999, 2'b00, 0, 0, 10'h0, 16'h0, 2,
                ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
        check("rst_ack", ack1, 1);
        check("rst_no_rdy", n_rdy, 0);
        check("rst_no_dst", n_dst, 0);
        run_txn(1'b1, 1'b0, 22'h000020, 16'h0, 2'b00, 0, 0, 10'h0, 16'h0, 0,
                ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
        check("post_rst_ack", ack1, 1);
        check("post_rst_data", int'(rdat), 16'h1111);

        // Request level held across two reads.
        run_txn(1'b1, 1'b0, 22'h000005, 16'h0, 2'b00, 8, 0, 10'h0, 16'h0, 0,
                ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
        check("hold_counts", n_ack * 100 + n_dst * 10 + n_rdy, 222);
        check("hold_first", ack1 * 100 + dst1 * 10 + rdy1, 145);
        check("hold_second_ack", ack2, 7);
        check("hold_data", int'(rdat), 16'hBEEF);

        // Preload collides with a committed write to the same word.
        run_txn(1'b0, 1'b1, 22'h000040, 16'h2222, 2'b00, 0, 3, 10'h040, 16'h3333, 0,
                ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
        check("coll_rdy", rdy1, 4);
        run_txn(1'b1, 1'b0, 22'h000040, 16'h0, 2'b00, 0, 0, 10'h0, 16'h0, 0,
                ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
        check("coll_data", int'(rdat), 16'h3333);

        // Downloading blocks requests while preload writes proceed.
        @(negedge clk);
        downloading = 1'b1; ba_rd = 1'b1; ba_addr = 22'h000030;
        for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = 10'(10'h030 + i); prog_data = 16'(16'h7770 + i);
            @(negedge clk);
            check($sformatf("dl_no_ack%0d", i), int'(ba_ack), 0);
        end
        ba_rd = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        check("dl_no_ack_end", int'(ba_ack), 0);
        downloading = 1'b0;
        run_txn(1'b1, 1'b0, 22'h000031, 16'h0, 2'b00, 0, 0, 10'h0, 16'h0, 0,
                ack1, ack2, dst1, rdy1, n_ack, n_dst, n_rdy, rdat);
        check("dl_data", int'(rdat), 16'h7771);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtframe_bank_resp.md
JTFRAME_BANK_RESP -- requirements
Module: jtframe_bank_resp

Interface
REQ-001 Parameter AW, default 22, meaning: requester word-address width.
REQ-002 Parameter MEMAW, default 10, meaning: BRAM depth in 16-bit words, 2^MEMAW; must be at most AW.
REQ-003 Parameter LATENCY, default 3, meaning: wait cycles between ack and data; legal range 1-15.
REQ-004 Port rst, input, 1, meaning: asynchronous, active-high reset.
REQ-005 Port clk, input, 1, meaning: single clock; all logic runs on its rising edge.
REQ-006 Port ba_addr, input, AW, meaning: word address of the request.
REQ-007 Port ba_rd, input, 1, meaning: read request level, held by the requester until ack.
REQ-008 Port ba_wr, input, 1, meaning: write request level, held by the requester until ack.
REQ-009 Port ba_din, input, 16, meaning: write data.
REQ-010 Port ba_din_m, input, 2, meaning: byte mask; bit set means that byte is not written (bit1 = upper byte, bit0 = lower byte).
REQ-011 Port ba_ack, output, 1, meaning: one-cycle pulse when a request is accepted.
REQ-012 Port ba_dst, output, 1, meaning: one-cycle pulse when data_read is valid (reads only).
REQ-013 Port ba_rdy, output, 1, meaning: one-cycle pulse when the transaction completes.
REQ-014 Port data_read, output, 16, meaning: read data, registered.
REQ-015 Port downloading, input, 1, meaning: preload mode; requests are not accepted while high.
REQ-016 Port prog_we, input, 1, meaning: preload write strobe.
REQ-017 Port prog_addr, input, MEMAW, meaning: preload word address.
REQ-018 Port prog_data, input, 16, meaning: preload data, always written as a full word.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DATA and DONE.
REQ-020 In IDLE with (ba_rd|ba_wr) high and downloading low, the block SHALL capture addr, din, din_m and type at edge N, assert ba_ack in cycle N+1, and enter WAIT.
REQ-021 If ba_rd and ba_wr are both high, the request SHALL be treated as a write.
REQ-022 WAIT SHALL count LATENCY cycles; the counter width is 4 bits and it loads LATENCY-1 on entry.
REQ-023 Read: the BRAM is read at the last WAIT cycle; data_read updates and ba_dst pulses in cycle N+1+LATENCY (DATA); ba_rdy pulses in cycle N+2+LATENCY (DONE).
REQ-024 Write: the unmasked bytes are committed at the last WAIT cycle; ba_rdy pulses in cycle N+1+LATENCY; ba_dst never asserts.
REQ-025 After DONE (or after the write rdy cycle) the FSM SHALL return to IDLE; a pending request is acked one cycle later at the earliest, so back-to-back transactions are spaced by at least one idle cycle.
REQ-026 Requests arriving outside IDLE SHALL be ignored, with no ack, until IDLE; the request level remaining high after ack SHALL NOT start a new transaction until the rdy cycle has passed.
REQ-027 Address bits above MEMAW SHALL be ignored, so addresses wrap modulo 2^MEMAW.
REQ-028 A write with ba_din_m=2'b11 SHALL complete the handshake normally and leave memory unchanged.
REQ-029 prog_we with downloading high SHALL write prog_data to prog_addr in the same edge, in any FSM state.
REQ-030 If prog_we and a committed write hit the same cycle, prog_we SHALL win for that address.
REQ-031 data_read SHALL hold its last read value between reads.
REQ-032 ba_ack, ba_dst and ba_rdy SHALL each be high for exactly one cycle per transaction and are mutually exclusive in any cycle.

Reset
REQ-033 Reset SHALL asynchronously force state=IDLE, ba_ack=0, ba_dst=0, ba_rdy=0, data_read=0 and counter=0.
REQ-034 Reset mid-transaction SHALL abort it with no rdy; a write not yet committed SHALL be dropped; BRAM contents SHALL be retained.
REQ-035 After reset release, the first request SHALL be acked in the cycle after it is sampled in IDLE.

Verification
REQ-036 LATENCY=3: preload 0x005=0xBEEF; read 0x005 sampled at cycle 0 -> ack at 1, dst at 4 with data_read=0xBEEF, rdy at 5.
REQ-037 Write 0x010 with din=0x1234, din_m=2'b10 over prior 0xFFFF -> ack at 1, rdy at 4, no dst; read back gives 0xFF34.
REQ-038 ba_rd and ba_wr high together at 0x3FF with din=0xA5A5 -> treated as write; read back 0xA5A5; address 0x7FF aliases to the same word (MEMAW=10).
REQ-039 Assert rst during WAIT of a write to 0x020 -> all outputs 0 immediately, no rdy, word 0x020 unchanged; the next request is acked normally.
REQ-040 Request held continuously for two reads -> exactly two ack/dst/rdy triples, with the second ack no earlier than the cycle after the first rdy plus one; with downloading=1 a request is never acked while prog_we writes succeed.
